mem_secded_scrub: RTL

Parametrised SEC-DED protected register-file memory.
- Encodes on write and stores the extended-Hamming codeword.
- Decodes and corrects on read, with a registered read port.
- A background scrubber walks idle cycles through every word and writes corrected codewords back.
- Sits between the host datapath and storage; saturating error counters and last-error address feed the status block.

---
 rtl/mem_secded_scrub_if.sv | 58 +++++
 rtl/mem_secded_scrub.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_secded_scrub_if.sv
// Host-side bus of the SEC-DED scrubbed memory.
// The master modport is the host datapath; the slave modport is the memory.
// Optional macro ERR_INJECT_EN adds the inj_mask fault-injection signal.
interface mem_secded_scrub_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);

`ifdef ERR_INJECT_EN
    // Number of Hamming check bits for DATA_W data bits
    function automatic int calc_check_w(input int dw);
        int r;
        r = 1;
        while ((2 ** r) < (dw + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int CHECK_W = calc_check_w(DATA_W);

    logic [DATA_W+CHECK_W:0] inj_mask;
`endif

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              scrub_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              sec_err;
    logic              ded_err;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;
    logic [ADDR_W-1:0] err_addr;
    logic              scrub_wrap;

    modport master (
        output wr_en, rd_en, addr, data_in, scrub_en,
`ifdef ERR_INJECT_EN
        output inj_mask,
`endif
        input  rd_data, rd_valid, sec_err, ded_err,
        input  sec_cnt, ded_cnt, err_addr, scrub_wrap
    );

    modport slave (
        input  wr_en, rd_en, addr, data_in, scrub_en,
`ifdef ERR_INJECT_EN
        input  inj_mask,
`endif
        output rd_data, rd_valid, sec_err, ded_err,
        output sec_cnt, ded_cnt, err_addr, scrub_wrap
    );

endinterface

// File: rtl/mem_secded_scrub.sv
// SEC-DED protected register-file memory with background scrubber.
// Words are stored as extended Hamming codewords: bit p (1..N) is Hamming
// position p, bit 0 is overall even parity. Reads are corrected and
// registered; a scrubber uses idle cycles to repair single-bit errors.
// Optional macro ERR_INJECT_EN: host writes store codeword ^ bus.inj_mask.
module mem_secded_scrub #(
    parameter int DATA_W         = 12,
    parameter int ADDR_W         = 4,
    parameter int CNT_W          = 8,
    parameter int SCRUB_INTERVAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    mem_secded_scrub_if.slave bus
);

    // Number of Hamming check bits for DATA_W data bits
    function automatic int calc_check_w(input int dw);
        int r;
        r = 1;
        while ((2 ** r) < (dw + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int CHECK_W = calc_check_w(DATA_W);
    localparam int CW      = DATA_W + CHECK_W + 1;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int TMR_W   = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    typedef struct packed {
        logic              sec;
        logic              ded;
        logic [DATA_W-1:0] data;
        logic [CW-1:0]     fixed;
    } dec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_FIX  = 2'd2,
        S_ADV  = 2'd3
    } scrub_state_t;

    // Place data at non-power-of-two positions, fill check bits, then overall parity
    function automatic logic [CW-1:0] secded_encode(input logic [DATA_W-1:0] data);
        logic [CW-1:0] cw;
        int            di;
        cw = '0;
        di = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = data[di];
                di    = di + 1;
            end else begin
                cw[p] = 1'b0;
            end
        end
        for (int i = 0; i < CHECK_W; i++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p < CW; p++) begin
                if (((p >> i) & 1) != 0) begin
                    par = par ^ cw[p];
                end else begin
                    par = par;
                end
            end
            cw[1 << i] = par;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Syndrome + overall parity classify the word; single errors are flipped back
    function automatic dec_t secded_decode(input logic [CW-1:0] cw);
        dec_t               r;
        logic [CHECK_W-1:0] syn;
        logic               par_bad;
        int                 di;
        syn = '0;
        for (int p = 1; p < CW; p++) begin
            if (cw[p]) begin
                syn = syn ^ CHECK_W'(p);
            end else begin
                syn = syn;
            end
        end
        par_bad = ^cw;
        r.sec   = 1'b0;
        r.ded   = 1'b0;
        r.fixed = cw;
        if (!par_bad) begin
            r.ded = (syn != '0);
        end else if (int'(syn) < CW) begin
            // syndrome 0 points at the overall parity bit itself
            r.sec        = 1'b1;
            r.fixed[syn] = ~cw[syn];
        end else begin
            // syndrome beyond the codeword cannot be a single-bit error
            r.ded = 1'b1;
        end
        r.data = '0;
        di     = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.data[di] = r.fixed[p];
                di         = di + 1;
            end else begin
                di = di;
            end
        end
        return r;
    endfunction

    logic [CW-1:0]     mem_q [DEPTH];
    scrub_state_t      state_q, state_d;
    logic [ADDR_W-1:0] scrub_ptr_q, scrub_ptr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CW-1:0]     fix_cw_q, fix_cw_d;
    logic              scrub_wrap_q, scrub_wrap_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, sec_err_q, ded_err_q;
    logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic              host_busy_s, host_rd_s;
    logic [ADDR_W-1:0] rd_addr_s;
    dec_t              dec_s;
    logic              scrub_det_s, scrub_we_s;
    logic              det_sec_s, det_ded_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [CW-1:0]     mem_wdata_s;
    logic [CW-1:0]     host_cw_s;

    // Shared decoder: a host read wins the read port, otherwise the scrub pointer
    always_comb begin
        host_busy_s = bus.wr_en | bus.rd_en;
        host_rd_s   = bus.rd_en & ~bus.wr_en;
        rd_addr_s   = host_rd_s ? bus.addr : scrub_ptr_q;
        dec_s       = secded_decode(mem_q[rd_addr_s]);
    end

    // Scrubber next-state logic; host traffic stalls READ and FIX
    always_comb begin
        state_d      = state_q;
        scrub_ptr_d  = scrub_ptr_q;
        timer_d      = timer_q;
        fix_cw_d     = fix_cw_q;
        scrub_wrap_d = 1'b0;
        scrub_det_s  = 1'b0;
        scrub_we_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.scrub_en) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d = S_READ;
                end else if (!host_busy_s) begin
                    timer_d = timer_q - TMR_W'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            S_READ: begin
                if (!bus.scrub_en) begin
                    state_d = S_IDLE;
                end else if (host_busy_s) begin
                    state_d = S_READ;
                end else begin
                    scrub_det_s = 1'b1;
                    if (dec_s.sec) begin
                        fix_cw_d = dec_s.fixed;
                        state_d  = S_FIX;
                    end else begin
                        state_d = S_ADV;
                    end
                end
            end
            S_FIX: begin
                if (bus.wr_en && (bus.addr == scrub_ptr_q)) begin
                    // host rewrote the word; the pending repair is stale
                    state_d = S_ADV;
                end else if (host_busy_s) begin
                    state_d = S_FIX;
                end else begin
                    scrub_we_s = 1'b1;
                    state_d    = S_ADV;
                end
            end
            S_ADV: begin
                scrub_ptr_d  = scrub_ptr_q + ADDR_W'(1);
                timer_d      = TMR_W'(SCRUB_INTERVAL);
                scrub_wrap_d = (scrub_ptr_q == PTR_LAST);
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Detection events and memory write-port selection
    always_comb begin
        det_sec_s = (host_rd_s | scrub_det_s) & dec_s.sec;
        det_ded_s = (host_rd_s | scrub_det_s) & dec_s.ded;
`ifdef ERR_INJECT_EN
        host_cw_s = secded_encode(bus.data_in) ^ bus.inj_mask;
`else
        host_cw_s = secded_encode(bus.data_in);
`endif
        if (bus.wr_en) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = bus.addr;
            mem_wdata_s = host_cw_s;
        end else if (scrub_we_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = scrub_ptr_q;
            mem_wdata_s = fix_cw_q;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = '0;
            mem_wdata_s = '0;
        end
    end

    // Codeword storage, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Scrubber registers; reset drops any pending write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            scrub_ptr_q  <= '0;
            timer_q      <= '0;
            fix_cw_q     <= '0;
            scrub_wrap_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scrub_ptr_q  <= scrub_ptr_d;
            timer_q      <= timer_d;
            fix_cw_q     <= fix_cw_d;
            scrub_wrap_q <= scrub_wrap_d;
        end
    end

    // Registered read port; flags only accompany an accepted host read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            sec_err_q  <= 1'b0;
            ded_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= host_rd_s;
            sec_err_q  <= host_rd_s & dec_s.sec;
            ded_err_q  <= host_rd_s & dec_s.ded;
            if (host_rd_s) begin
                rd_data_q <= dec_s.data;
            end
        end
    end

    // Saturating error counters and last-error address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            if (det_sec_s && (sec_cnt_q != CNT_MAX)) begin
                sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            end
            if (det_ded_s && (ded_cnt_q != CNT_MAX)) begin
                ded_cnt_q <= ded_cnt_q + CNT_W'(1);
            end
            if (det_sec_s || det_ded_s) begin
                err_addr_q <= rd_addr_s;
            end
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.sec_err    = sec_err_q;
    assign bus.ded_err    = ded_err_q;
    assign bus.sec_cnt    = sec_cnt_q;
    assign bus.ded_cnt    = ded_cnt_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.scrub_wrap = scrub_wrap_q;

endmodule
